// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
// Glyphs are active-high with bit 0 = segment a through bit 6 = segment g.
package seg_pkg;

   localparam logic [6:0] SEG_OFF  = 7'h00;
   localparam logic [6:0] SEG_DASH = 7'h40;

   localparam logic [6:0] SEG_GLYPH [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic {
      ST_DEAD = 1'b0,
      ST_ON   = 1'b1
   } scan_state_e;

   // Codes 10-15 fall back to a dash when hex glyphs are disabled.
   function automatic logic [6:0] seg_decode(input logic [3:0] code, input bit hex_en);
      if (code > 4'd9 && !hex_en) return SEG_DASH;
      return SEG_GLYPH[code];
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bundle between the score logic (master) and the scan driver (slave):
// digit codes and controls in, board seg/dp/an pins and frame marker out.
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);

   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic                    lz_blank;
   logic                    load;

   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_start;

   modport master (
      output digits_in, dp_in, blink_mask, lz_blank, load,
      input  seg, dp, an, frame_start
   );

   modport slave (
      input  digits_in, dp_in, blink_mask, lz_blank, load,
      output seg, dp, an, frame_start
   );

endinterface

// File: rtl/seg_tick_div.sv
// Free-running slot divider: tick_o is high during the last cycle of every
// REFRESH_DIV-cycle digit slot.
module seg_tick_div #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int             CW   = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]  LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] div_cnt_q, div_cnt_d;

   assign tick_o = (div_cnt_q == LAST);

   always_comb begin
      div_cnt_d = tick_o ? '0 : div_cnt_q + 1'b1;
   end

   // NOTE: sequential state is written with <= only, so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) div_cnt_q <= '0;
      else     div_cnt_q <= div_cnt_d;
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with anode dead-time, leading-zero
// blanking, per-digit blink and tear-free frame-synchronous snapshot loading.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int DEAD_CYCLES    = 0,
   parameter int BLINK_DIV      = 64,
   parameter bit HEX_EN         = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   seg_scan_driver_if.slave  bus
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0]         BLINK_TOP = BW'(BLINK_DIV - 1);
   localparam logic [DW-1:0]         DEAD_INIT = DW'(DEAD_CYCLES);
   localparam logic [6:0]            SEG_IDLE  = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
   localparam logic                  DP_IDLE   = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_IDLE   = {NUM_DIGITS{AN_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

   logic tick;

   seg_tick_div #(.REFRESH_DIV(REFRESH_DIV)) u_tick_div (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   scan_state_e             state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [DW-1:0]           dead_q, dead_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    fs_q, fs_d;
   logic                    blank_q, blank_d;
   logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic [NUM_DIGITS-1:0]   pend_bm_q, pend_bm_d, disp_bm_q, disp_bm_d;
   logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
   logic                    blink_hide_q, blink_hide_d;

   logic          wrap;
   logic [IW-1:0] nxt_idx;
   logic [3:0]    nxt_code;
   logic          lz_hit;
   logic          blank_now;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      dead_d       = dead_q;
      seg_d        = seg_q;
      dp_d         = dp_q;
      an_d         = an_q;
      fs_d         = 1'b0;
      blank_d      = blank_q;
      pend_dig_d   = pend_dig_q;
      pend_dp_d    = pend_dp_q;
      pend_bm_d    = pend_bm_q;
      disp_dig_d   = disp_dig_q;
      disp_dp_d    = disp_dp_q;
      disp_bm_d    = disp_bm_q;
      blink_cnt_d  = blink_cnt_q;
      blink_hide_d = blink_hide_q;
      nxt_idx      = '0;
      nxt_code     = '0;
      lz_hit       = 1'b0;
      blank_now    = 1'b0;

      wrap = tick && (idx_q == LAST_IDX);

      if (bus.load) begin
         pend_dig_d = bus.digits_in;
         pend_dp_d  = bus.dp_in;
         pend_bm_d  = bus.blink_mask;
      end

      // Display regs change only at the frame boundary; a load on that very
      // edge bypasses pending so the new value is not a frame late.
      if (wrap) begin
         fs_d       = 1'b1;
         disp_dig_d = bus.load ? bus.digits_in  : pend_dig_q;
         disp_dp_d  = bus.load ? bus.dp_in      : pend_dp_q;
         disp_bm_d  = bus.load ? bus.blink_mask : pend_bm_q;
         if (blink_cnt_q == BLINK_TOP) begin
            blink_cnt_d  = '0;
            blink_hide_d = ~blink_hide_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end

      if (tick) begin
         nxt_idx  = wrap ? '0 : idx_q + 1'b1;
         nxt_code = disp_dig_d[4*nxt_idx +: 4];
         lz_hit   = bus.lz_blank && (nxt_code == 4'd0) && (nxt_idx != '0);
         for (int j = 1; j < NUM_DIGITS; j++) begin
            if (j > int'(nxt_idx) && disp_dig_d[4*j +: 4] != 4'd0) lz_hit = 1'b0;
         end
         blank_now = lz_hit || (disp_bm_d[nxt_idx] && blink_hide_d);

         idx_d   = nxt_idx;
         blank_d = blank_now;
         seg_d   = blank_now ? SEG_IDLE : (seg_decode(nxt_code, HEX_EN) ^ {7{SEG_ACTIVE_LOW}});
         dp_d    = blank_now ? DP_IDLE  : (disp_dp_d[nxt_idx] ^ SEG_ACTIVE_LOW);

         if (DEAD_CYCLES == 0) begin
            state_d = ST_ON;
            an_d    = blank_now ? AN_IDLE : ((AN_ONE << nxt_idx) ^ AN_IDLE);
         end else begin
            state_d = ST_DEAD;
            dead_d  = DEAD_INIT;
            an_d    = AN_IDLE;
         end
      end else if (state_q == ST_DEAD) begin
         dead_d = dead_q - 1'b1;
         if (dead_q == DW'(1)) begin
            state_d = ST_ON;
            an_d    = blank_q ? AN_IDLE : ((AN_ONE << idx_q) ^ AN_IDLE);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ON;
         idx_q        <= '0;
         dead_q       <= '0;
         seg_q        <= SEG_IDLE;
         dp_q         <= DP_IDLE;
         an_q         <= AN_IDLE;
         fs_q         <= 1'b0;
         blank_q      <= 1'b0;
         pend_dig_q   <= '0;
         pend_dp_q    <= '0;
         pend_bm_q    <= '0;
         disp_dig_q   <= '0;
         disp_dp_q    <= '0;
         disp_bm_q    <= '0;
         blink_cnt_q  <= '0;
         blink_hide_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         dead_q       <= dead_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         fs_q         <= fs_d;
         blank_q      <= blank_d;
         pend_dig_q   <= pend_dig_d;
         pend_dp_q    <= pend_dp_d;
         pend_bm_q    <= pend_bm_d;
         disp_dig_q   <= disp_dig_d;
         disp_dp_q    <= disp_dp_d;
         disp_bm_q    <= disp_bm_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_hide_q <= blink_hide_d;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.an          = an_q;
   assign bus.frame_start = fs_q;

endmodule
